// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: FSM encoding and iteration count.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mul_seq_pkg;

  // Datapath width, fixed by the shared adder.
  localparam int WIDTH = 16;

  // One shift-add iteration per multiplier bit.
  localparam int ITERS = 16;

  // Iteration counter width and terminal value.
  localparam int          CNT_W    = 4;
  localparam logic [3:0]  CNT_LAST = 4'(ITERS - 1);

  // FSM encoding (3-bit).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    ITER   = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Product sign for a signed request: negative only when operand signs differ.
  function automatic logic result_negative(input logic is_signed,
                                           input logic [15:0] op_a,
                                           input logic [15:0] op_b);
    return is_signed & (op_a[15] ^ op_b[15]);
  endfunction

endpackage

// File: rtl/mul_seq_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry unit across groups.
// Latency: combinational.
// Backpressure: none.
module cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        si,
  output logic [15:0] out,
  output logic        ofl
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Bit generate/propagate, group lookahead, then carries within each group.
  always_comb begin
    g = a & b;
    p = a ^ b;

    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & gc[0]);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & gc[0]);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = gc[4];

    out = p ^ c[15:0];
    // si selects signed overflow; otherwise report the raw carry-out.
    ofl = si ? (c[16] ^ c[15]) : c[16];
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 16x16->32 multiplier (signed/unsigned) sharing one 16-bit CLA for negation and shift-add.
// Latency: 17 cycles unsigned, 19 signed with non-negative result, 21 signed with negative result.
// Backpressure: start is accepted only in IDLE; requests while busy or in DONE are dropped.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  state_t state;
  state_t state_nxt;

  logic [15:0]      acc_hi;
  logic [15:0]      acc_hi_nxt;
  logic [15:0]      mq;
  logic [15:0]      mq_nxt;
  logic [15:0]      mcand;
  logic [15:0]      mcand_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             neg_res;
  logic             neg_res_nxt;
  logic             c_fix;
  logic             c_fix_nxt;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_out;
  logic        add_ofl;

  // The single shared adder; si tied low so ofl is the unsigned carry-out.
  cla u_cla (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .si  (1'b0),
    .out (add_out),
    .ofl (add_ofl)
  );

  // Route adder operands according to the current phase.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      NEG_A: begin
        add_a   = ~mcand;
        add_cin = 1'b1;
      end
      NEG_B: begin
        add_a   = ~mq;
        add_cin = 1'b1;
      end
      ITER: begin
        add_a = acc_hi;
        add_b = mcand;
      end
      FIX_LO: begin
        add_a   = ~mq;
        add_cin = 1'b1;
      end
      FIX_HI: begin
        add_a   = ~acc_hi;
        add_cin = c_fix;
      end
      default: ;
    endcase
  end

  // Next-state and datapath register updates; everything holds unless the phase changes it.
  always_comb begin
    state_nxt   = state;
    acc_hi_nxt  = acc_hi;
    mq_nxt      = mq;
    mcand_nxt   = mcand;
    cnt_nxt     = cnt;
    neg_res_nxt = neg_res;
    c_fix_nxt   = c_fix;

    case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt   = a;
          mq_nxt      = b;
          acc_hi_nxt  = '0;
          cnt_nxt     = '0;
          neg_res_nxt = result_negative(signed_op, a, b);
          state_nxt   = signed_op ? NEG_A : ITER;
        end
      end
      NEG_A: begin
        // Only negative operands are replaced by their magnitude.
        if (mcand[15]) mcand_nxt = add_out;
        state_nxt = NEG_B;
      end
      NEG_B: begin
        if (mq[15]) mq_nxt = add_out;
        state_nxt = ITER;
      end
      ITER: begin
        // Carry-out of the partial sum shifts into the top of acc_hi.
        if (mq[0]) begin
          acc_hi_nxt = {add_ofl, add_out[15:1]};
          mq_nxt     = {add_out[0], mq[15:1]};
        end else begin
          acc_hi_nxt = {1'b0, acc_hi[15:1]};
          mq_nxt     = {acc_hi[0], mq[15:1]};
        end
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = neg_res ? FIX_LO : DONE;
        end
      end
      FIX_LO: begin
        mq_nxt    = add_out;
        c_fix_nxt = add_ofl;
        state_nxt = FIX_HI;
      end
      FIX_HI: begin
        acc_hi_nxt = add_out;
        state_nxt  = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; product captures the final value on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc_hi  <= '0;
      mq      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      c_fix   <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      acc_hi  <= acc_hi_nxt;
      mq      <= mq_nxt;
      mcand   <= mcand_nxt;
      cnt     <= cnt_nxt;
      neg_res <= neg_res_nxt;
      c_fix   <= c_fix_nxt;
      if ((state_nxt == DONE) && (state != DONE)) begin
        product <= {acc_hi_nxt, mq_nxt};
      end
    end
  end

  // Status decode straight from state.
  always_comb begin
    busy = (state != IDLE) && (state != DONE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: scoreboard of expected products and latencies, immediate-assert checks.
// Latency: measured in cycles from the start-accept edge (counted as cycle 1) to the done pulse.
// Backpressure: exercises start ignored while busy and reset mid-operation.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference product from the arithmetic definition.
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
    int sx;
    int sy;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 32'(sx * sy);
    end
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Expected latency: +2 for operand negation, +2 more when the result is negated.
  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y, input logic s);
    if (!s) return 17;
    if (x[15] ^ y[15]) return 21;
    return 19;
  endfunction

  // Issue one request and check it; optionally poke a second start at cycle poke_at.
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input int poke_at);
    exp_t e;
    int   n;
    logic busy_bad;
    logic [31:0] held;
    sb.push_back('{prod: ref_prod(x, y, s), lat: ref_lat(x, y, s)});
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    a         = x;
    b         = y;
    @(posedge clk);
    #1;
    start     = 1'b0;
    n         = 1;
    busy_bad  = 1'b0;
    while (!done && n < 40) begin
      if (!busy) busy_bad = 1'b1;
      if (n == poke_at) begin
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0001;
        signed_op = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
      chk({tag, " busy_between"}, {31'd0, busy_bad}, 32'd0);
      chk({tag, " latency"}, 32'(n), 32'(e.lat));
      chk({tag, " product"}, product, e.prod);
      held = e.prod;
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, " product_hold"}, product, held);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u3x5", 16'd3, 16'd5, 1'b0, 0);
    do_op("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_op("s-3x5", 16'hFFFD, 16'd5, 1'b1, 0);
    do_op("s8000x8000", 16'h8000, 16'h8000, 1'b1, 0);
    do_op("s-1x0", 16'hFFFF, 16'h0000, 1'b1, 0);
    do_op("u7x9_poke", 16'd7, 16'd9, 1'b0, 5);

    // Abort a request with reset in its 8th ITER cycle.
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    a         = 16'd2;
    b         = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u2x3_fresh", 16'd2, 16'd3, 1'b0, 0);

    // A few random requests of both signedness.
    for (int i = 0; i < 6; i++) begin
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle 16x16 -> 32-bit multiplier sequencer for the execute stage; its output drives the MUL result path.
- Time-multiplexes a single 16-bit carry-lookahead adder (`cla`, 16-bit A/B, Cin, Si, Out, Ofl).
- Operand negation for signed mode, shift-add iterations and result negation all go through that one adder.
- Start/busy/done handshake; the pipeline stalls while busy is high.

Parameters:
- None. Width is fixed at 16 to match the adder; the iteration count is the constant ITERS = 16.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  in  16  multiplicand; sampled with start
- b  in  16  multiplier; sampled with start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse, high while in DONE
- product  out  32  result; valid from DONE until the next accepted start

Behaviour:
- Reset (sync, active-high), applied in any state including mid-operation:
  - next state IDLE; busy=0, done=0, product=0;
  - internal registers cleared: acc_hi, mq, mcand, cnt, neg_res.
- The adder is combinational inside the block; its inputs are muxed by state.
  - Si is always 0, so Ofl is the unsigned carry-out (C16).
- IDLE:
  - start=1 latches a->mcand, b->mq, acc_hi=0, cnt=0, neg_res=signed_op&(a[15]^b[15]).
  - Next state is NEG_A if signed_op, else ITER. start=0 stays in IDLE.
- NEG_A:
  - Adder computes A=~mcand, B=0, Cin=1.
  - If mcand[15], mcand<=Out; otherwise mcand unchanged.
  - Next state NEG_B.
- NEG_B: same operation applied to mq; next state ITER.
- ITER, one iteration per cycle for 16 cycles:
  - Adder computes A=acc_hi, B=mcand, Cin=0.
  - If mq[0]: {acc_hi,mq} <= {Ofl,Out,mq[15:1]}. Else: {acc_hi,mq} <= {1'b0,acc_hi,mq[15:1]}.
  - cnt increments every ITER cycle. When cnt==15: next state is FIX_LO if neg_res, else DONE.
- FIX_LO:
  - Adder computes A=~mq, B=0, Cin=1; mq<=Out; carry flop c<=Ofl.
  - Next state FIX_HI.
- FIX_HI:
  - Adder computes A=~acc_hi, B=0, Cin=c; acc_hi<=Out.
  - Next state DONE.
- DONE:
  - done=1, busy=0, product={acc_hi,mq}.
  - Next state IDLE unconditionally.
  - start asserted in DONE is ignored; requester re-asserts in IDLE.
- Product register: loads on the entry into DONE; holds through IDLE; cleared only by rst.
- Latency from the start-accept edge to the done pulse:
  - unsigned: 17 cycles;
  - signed, non-negative result: 19 cycles;
  - signed, negative result: 21 cycles.
- start while busy is ignored. Operands are not re-sampled during an operation.
- Boundary cases:
  - Magnitude of -32768 is 0x8000, correct when treated as unsigned.
  - Zero operand with opposite signs still sets neg_res; negating 0 yields 0 with carry 1, final product 0.
  - Carry out of bit 15 during ITER must be kept via Ofl; 0xFFFF*0xFFFF exercises this.

Decomposition:
- Shared package `mul_seq_pkg`:
  - state encoding localparams IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE (3-bit);
  - constant ITERS=16.
- One sub-module: the existing 16-bit adder `cla`, instantiated once.
- FSM, operand muxing and shift registers stay in mul_seq. No separate datapath module.

Test Plan:
- Unsigned small operands: a=3, b=5, signed_op=0, start for one cycle -> done exactly 17 cycles later, product=0x0000000F; busy high for the 16 cycles between.
- Unsigned carry path: a=0xFFFF, b=0xFFFF, signed_op=0 -> product=0xFFFE0001, latency 17.
- Signed, negative result: a=0xFFFD (-3), b=5, signed_op=1 -> product=0xFFFFFFF1, latency 21.
- Signed, both at minimum: a=0x8000, b=0x8000, signed_op=1 -> product=0x40000000, latency 19.
- Signed zero case: a=0xFFFF (-1), b=0, signed_op=1 -> product=0x00000000, latency 21.
- Handshake and reset:
  - Start a=7, b=9; pulse start again at cycle 5 with a=1, b=1 -> second request ignored, product=0x0000003F.
  - Then start a=2, b=3; assert rst at the 8th ITER cycle -> next cycle busy=0, done=0, product=0.
  - Then a fresh start with a=2, b=3 -> product=6 after 17 cycles.
